// File: rtl/calc_entry_sequencer_if.sv
// Keypad strobe/code, chaining result and operand/status outputs of the
// calculator entry sequencer, bundled for connection to the display and ALU side.
interface calc_entry_sequencer_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   result_bcd;
    logic [1:0]            curr_state;
    logic [4*DIGITS-1:0]   num1_bcd;
    logic [4*DIGITS-1:0]   num2_bcd;
    logic [1:0]            operation;
    logic                  alu_start;
    logic                  entry_full;

    modport master (
        output key_valid, key_code, result_bcd,
        input  curr_state, num1_bcd, num2_bcd, operation, alu_start, entry_full
    );

    modport slave (
        input  key_valid, key_code, result_bcd,
        output curr_state, num1_bcd, num2_bcd, operation, alu_start, entry_full
    );
endinterface

// File: rtl/calc_entry_sequencer.sv
// Calculator keypad front-end: walks N1 -> OP -> N2 -> EQ, assembles BCD operands
// digit by digit, latches the operation and pulses alu_start on '='.
module calc_entry_sequencer #(
    parameter int unsigned DIGITS  = 4,
    parameter logic [3:0]  KEY_EQ  = 4'hE,
    parameter logic [3:0]  KEY_CLR = 4'hF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    calc_entry_sequencer_if.slave bus_io
);
    localparam int unsigned   W        = 4 * DIGITS;
    localparam int unsigned   CW       = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    typedef enum logic [1:0] {
        ST_N1 = 2'b00,
        ST_OP = 2'b01,
        ST_N2 = 2'b10,
        ST_EQ = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic          key_q, armed_q;
    logic [W-1:0]  num1_q, num1_d, num2_q, num2_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          alu_start_q, alu_start_d;
    logic          entry_full_q, entry_full_d;

    logic          accept_s, is_digit_s, is_op_s, is_eq_s, is_clr_s;
    logic          take1_s, take2_s;
    logic [3:0]    code_s;
    logic [1:0]    code_op_s;
    logic [W-1:0]  digit_ext_s;
    logic [CW-1:0] first_cnt_s;

    // A digit is absorbed unless the operand is full or it would be a leading zero
    function automatic logic digit_takes(input logic [W-1:0] operand,
                                         input logic [CW-1:0] cnt,
                                         input logic [3:0] digit);
        return (cnt != CNT_FULL) && !((digit == 4'd0) && (operand == {W{1'b0}}));
    endfunction

    // armed_q blocks a key that was already held when reset released
    assign code_s      = bus_io.key_code;
    assign accept_s    = bus_io.key_valid & ~key_q & armed_q;
    assign is_digit_s  = (code_s <= 4'd9);
    assign is_op_s     = (code_s >= 4'hA) && (code_s <= 4'hD);
    assign is_eq_s     = (code_s == KEY_EQ);
    assign is_clr_s    = (code_s == KEY_CLR);
    assign code_op_s   = 2'(code_s - 4'hA);
    assign digit_ext_s = {{(W-4){1'b0}}, code_s};
    assign first_cnt_s = (code_s != 4'd0) ? CW'(1) : CW'(0);
    assign take1_s     = digit_takes(num1_q, cnt_q, code_s);
    assign take2_s     = digit_takes(num2_q, cnt_q, code_s);

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_N1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from the accepted key
    always_comb begin
        state_d = state_q;
        if (accept_s && is_clr_s) begin
            state_d = ST_N1;
        end else if (accept_s) begin
            case (state_q)
                ST_N1:   state_d = is_op_s ? ST_OP : ST_N1;
                ST_OP:   state_d = is_digit_s ? ST_N2 : ST_OP;
                ST_N2:   state_d = is_eq_s ? ST_EQ : ST_N2;
                ST_EQ: begin
                    if (is_digit_s) begin
                        state_d = ST_N1;
                    end else if (is_op_s) begin
                        state_d = ST_OP;
                    end else begin
                        state_d = ST_EQ;
                    end
                end
                default: state_d = ST_N1;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Operand, operation, counter and status updates
    always_comb begin
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        alu_start_d = 1'b0;
        if (accept_s && is_clr_s) begin
            num1_d = {W{1'b0}};
            num2_d = {W{1'b0}};
            op_d   = 2'b00;
            cnt_d  = CW'(0);
        end else if (accept_s) begin
            case (state_q)
                ST_N1: begin
                    if (is_digit_s && take1_s) begin
                        num1_d = {num1_q[W-5:0], code_s};
                        cnt_d  = cnt_q + CW'(1);
                    end else if (is_op_s) begin
                        op_d  = code_op_s;
                        cnt_d = CW'(0);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_OP: begin
                    if (is_op_s) begin
                        op_d = code_op_s;
                    end else if (is_digit_s) begin
                        num2_d = digit_ext_s;
                        cnt_d  = first_cnt_s;
                    end else begin
                        op_d = op_q;
                    end
                end
                ST_N2: begin
                    if (is_digit_s && take2_s) begin
                        num2_d = {num2_q[W-5:0], code_s};
                        cnt_d  = cnt_q + CW'(1);
                    end else if (is_eq_s) begin
                        alu_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_EQ: begin
                    if (is_digit_s) begin
                        num1_d = digit_ext_s;
                        num2_d = {W{1'b0}};
                        op_d   = 2'b00;
                        cnt_d  = first_cnt_s;
                    end else if (is_op_s) begin
                        num1_d = bus_io.result_bcd;
                        num2_d = {W{1'b0}};
                        op_d   = code_op_s;
                        cnt_d  = CW'(0);
                    end else begin
                        op_d = op_q;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
        entry_full_d = ((state_d == ST_N1) || (state_d == ST_N2)) && (cnt_d == CNT_FULL);
    end

    // Key edge detection and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q        <= 1'b0;
            armed_q      <= 1'b0;
            num1_q       <= {W{1'b0}};
            num2_q       <= {W{1'b0}};
            op_q         <= 2'b00;
            cnt_q        <= CW'(0);
            alu_start_q  <= 1'b0;
            entry_full_q <= 1'b0;
        end else begin
            key_q        <= bus_io.key_valid;
            armed_q      <= armed_q | ~bus_io.key_valid;
            num1_q       <= num1_d;
            num2_q       <= num2_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            alu_start_q  <= alu_start_d;
            entry_full_q <= entry_full_d;
        end
    end

    assign bus_io.curr_state = state_q;
    assign bus_io.num1_bcd   = num1_q;
    assign bus_io.num2_bcd   = num2_q;
    assign bus_io.operation  = op_q;
    assign bus_io.alu_start  = alu_start_q;
    assign bus_io.entry_full = entry_full_q;
endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Scoreboard bench for calc_entry_sequencer: a decimal-arithmetic reference model
// predicts every cycle, a negedge monitor pops and compares.
module tb_calc_entry_sequencer;
    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;

    calc_entry_sequencer_if #(.DIGITS(DIGITS)) bus ();

    calc_entry_sequencer #(.DIGITS(DIGITS), .KEY_EQ(4'hE), .KEY_CLR(4'hF)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic [1:0]  st;
        logic [15:0] n1;
        logic [15:0] n2;
        logic [1:0]  op;
        logic        alu;
        logic        full;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned edge_cnt = 0;

    // Reference model: operands held as plain decimal integers
    int m_state, m_num1, m_num2, m_op, m_cnt;
    bit m_alu, m_prev, m_armed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = 16'h0000;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int push_digit(input int v, input int d);
        if (m_cnt == DIGITS || (d == 0 && v == 0)) return v;
        m_cnt++;
        return v * 10 + d;
    endfunction

    task automatic model_reset_data();
        m_state = 0; m_num1 = 0; m_num2 = 0; m_op = 0; m_cnt = 0;
    endtask

    task automatic model_reset();
        model_reset_data();
        m_alu = 1'b0; m_prev = 1'b0; m_armed = 1'b0;
    endtask

    task automatic apply_key(input int code);
        if (code == 15) begin
            model_reset_data();
        end else if (code <= 9) begin
            case (m_state)
                0: m_num1 = push_digit(m_num1, code);
                1: begin m_num2 = code; m_cnt = (code != 0); m_state = 2; end
                2: m_num2 = push_digit(m_num2, code);
                default: begin
                    m_num1 = code; m_num2 = 0; m_op = 0; m_cnt = (code != 0); m_state = 0;
                end
            endcase
        end else if (code <= 13) begin
            case (m_state)
                0: begin m_op = code - 10; m_cnt = 0; m_state = 1; end
                1: m_op = code - 10;
                3: begin
                    m_num1 = from_bcd(bus.result_bcd); m_num2 = 0;
                    m_op = code - 10; m_cnt = 0; m_state = 1;
                end
                default: ;
            endcase
        end else if (m_state == 2) begin
            m_state = 3;
            m_alu = 1'b1;
        end
    endtask

    task automatic model_edge(input logic kv, input logic [3:0] code);
        bit acc;
        acc = kv && !m_prev && m_armed;
        m_alu = 1'b0;
        if (acc) apply_key(int'(code));
        m_prev = kv;
        if (!kv) m_armed = 1'b1;
    endtask

    // One clock: drive inputs, predict the next edge, queue the expectation
    task automatic step(input logic kv, input logic [3:0] code);
        exp_t e;
        bus.key_valid = kv;
        bus.key_code  = code;
        if (!rst_n) model_reset();
        else model_edge(kv, code);
        e.cyc  = edge_cnt + 1;
        e.st   = 2'(m_state);
        e.n1   = to_bcd(m_num1);
        e.n2   = to_bcd(m_num2);
        e.op   = 2'(m_op);
        e.alu  = m_alu;
        e.full = ((m_state == 0) || (m_state == 2)) && (m_cnt == DIGITS);
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        for (int i = 0; i < hold; i++) step(1'b1, code);
        for (int i = 0; i < gap; i++) step(1'b0, code);
    endtask

    task automatic check_now(input string tag, input logic [1:0] st, input logic [15:0] n1,
                             input logic [15:0] n2, input logic [1:0] op, input logic full);
        cmp({tag, "_state"}, bus.curr_state, st);
        cmp({tag, "_num1"},  bus.num1_bcd,   n1);
        cmp({tag, "_num2"},  bus.num2_bcd,   n2);
        cmp({tag, "_op"},    bus.operation,  op);
        cmp({tag, "_full"},  bus.entry_full, full);
    endtask

    // Monitor: compare the queued expectation for the edge just taken
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
            e = sb_q.pop_front();
            if (e.cyc < edge_cnt) begin
                cmp("sb_stale", e.cyc, edge_cnt);
            end else begin
                cmp("sb_state", bus.curr_state, e.st);
                cmp("sb_num1",  bus.num1_bcd,   e.n1);
                cmp("sb_num2",  bus.num2_bcd,   e.n2);
                cmp("sb_op",    bus.operation,  e.op);
                cmp("sb_alu",   bus.alu_start,  e.alu);
                cmp("sb_full",  bus.entry_full, e.full);
            end
        end
    end

    initial begin
        logic [3:0]  code;
        logic [15:0] rb;
        rst_n          = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.result_bcd = 16'h0000;
        model_reset();
        @(negedge clk);
        #1;
        check_now("reset", 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);
        cmp("reset_alu", bus.alu_start, 1'b0);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        rst_n = 1'b1;
        step(1'b0, 4'h0);

        // Basic 12 + 3 =
        press(4'h1, 1, 1); press(4'h2, 1, 1); press(4'hA, 1, 1); press(4'h3, 1, 1);
        press(4'hE, 1, 2);
        check_now("t1", 2'b11, 16'h0012, 16'h0003, 2'b00, 1'b0);
        press(4'hE, 1, 2);

        // Chain from EQ
        bus.result_bcd = 16'h0042;
        press(4'hC, 1, 1);
        check_now("t4", 2'b01, 16'h0042, 16'h0000, 2'b10, 1'b0);
        press(4'hF, 1, 1);
        check_now("clr_op", 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);

        // Operand overflow
        for (int d = 1; d <= 5; d++) press(4'(d), 1, 1);
        check_now("t2", 2'b00, 16'h1234, 16'h0000, 2'b00, 1'b1);
        press(4'hF, 1, 1);

        // Held key
        press(4'h7, 10, 1);
        check_now("t3", 2'b00, 16'h0007, 16'h0000, 2'b00, 1'b0);
        press(4'hF, 1, 1);

        // Leading zeros, operator overwrite, '=' in OP, '=' first in N2
        press(4'h0, 1, 1); press(4'h0, 1, 1);
        check_now("t5_zero", 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);
        for (int d = 1; d <= 4; d++) press(4'(d), 1, 1);
        press(4'hE, 1, 1);
        press(4'hA, 1, 1); press(4'hB, 1, 1); press(4'hE, 1, 1);
        check_now("t5_op", 2'b01, 16'h1234, 16'h0000, 2'b01, 1'b0);
        press(4'h5, 1, 1); press(4'hC, 1, 1); press(4'hE, 1, 1);
        check_now("t5_eq", 2'b11, 16'h1234, 16'h0005, 2'b01, 1'b0);
        press(4'hF, 1, 1);
        check_now("t6_clr", 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);

        // Async reset mid-N2, then key held across reset release
        press(4'h1, 1, 1); press(4'hA, 1, 1); press(4'h2, 1, 1); press(4'h3, 1, 1);
        rst_n = 1'b0;
        #1;
        check_now("t6_rst", 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);
        cmp("t6_rst_alu", bus.alu_start, 1'b0);
        step(1'b1, 4'h5);
        step(1'b1, 4'h5);
        rst_n = 1'b1;
        step(1'b1, 4'h5); step(1'b1, 4'h5); step(1'b1, 4'h5);
        check_now("held_rst", 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);
        step(1'b0, 4'h5);
        press(4'h5, 1, 1);
        check_now("rearm", 2'b00, 16'h0005, 16'h0000, 2'b00, 1'b0);

        // Randomized key traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 4; i++) rb[i*4 +: 4] = 4'($urandom_range(0, 9));
                bus.result_bcd = rb;
            end
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                step(1'($urandom_range(0, 1)), 4'h0);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 9) < 6) code = 4'($urandom_range(0, 9));
            else code = 4'($urandom_range(10, 15));
            press(code, $urandom_range(1, 3), $urandom_range(1, 2));
        end

        step(1'b0, 4'h0);
        cmp("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
